// File: rtl/rob_submit_arbiter.sv
// Funnels RS and LSB completions through per-requester FIFOs onto the ROB's
// single submit port, using a registered round-robin grant.
module rob_submit_arbiter #(
  parameter int TAG_W      = 4,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              predict_fail,
  input  logic              rs_valid,
  input  logic [TAG_W-1:0]  rs_tag,
  input  logic [DATA_W-1:0] rs_val,
  output logic              rs_ready,
  input  logic              lsb_valid,
  input  logic [TAG_W-1:0]  lsb_tag,
  input  logic [DATA_W-1:0] lsb_val,
  output logic              lsb_ready,
  output logic [TAG_W-1:0]  submit_tag,
  output logic [DATA_W-1:0] submit_val,
  output logic              submit_valid,
  output logic              busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W = TAG_W + DATA_W;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  // Requester index 0 = RS, 1 = LSB throughout.
  logic [ENT_W-1:0]  mem_q  [2][FIFO_DEPTH];
  logic [ENT_W-1:0]  mem_d  [2][FIFO_DEPTH];
  logic [PTR_W-1:0]  rptr_q [2];
  logic [PTR_W-1:0]  rptr_d [2];
  logic [PTR_W-1:0]  wptr_q [2];
  logic [PTR_W-1:0]  wptr_d [2];
  logic [CNT_W-1:0]  cnt_q  [2];
  logic [CNT_W-1:0]  cnt_d  [2];
  logic              prio_q, prio_d;
  logic              submit_valid_q, submit_valid_d;
  logic [TAG_W-1:0]  submit_tag_q, submit_tag_d;
  logic [DATA_W-1:0] submit_val_q, submit_val_d;

  logic [1:0]        ready;
  logic [1:0]        req;
  logic [1:0]        push;
  logic [1:0]        pop;
  logic [1:0]        cand;
  logic              gnt_sel;
  logic [ENT_W-1:0]  ent_in [2];
  logic [ENT_W-1:0]  head;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      ready[i] = (cnt_q[i] != CNT_FULL);
      cand[i]  = (cnt_q[i] != '0);
    end
  end

  assign req       = {lsb_valid, rs_valid};
  assign ent_in[0] = {rs_tag, rs_val};
  assign ent_in[1] = {lsb_tag, lsb_val};

  // Only entries present at the start of the cycle compete for the grant.
  assign gnt_sel = (cand == 2'b11) ? prio_q : cand[1];
  assign head    = mem_q[gnt_sel][rptr_q[gnt_sel]];

  always_comb begin
    mem_d          = mem_q;
    rptr_d         = rptr_q;
    wptr_d         = wptr_q;
    cnt_d          = cnt_q;
    prio_d         = prio_q;
    submit_valid_d = submit_valid_q;
    submit_tag_d   = submit_tag_q;
    submit_val_d   = submit_val_q;
    push           = '0;
    pop            = '0;

    if (rdy_in) begin
      if (predict_fail) begin
        for (int i = 0; i < 2; i++) begin
          rptr_d[i] = '0;
          wptr_d[i] = '0;
          cnt_d[i]  = '0;
        end
        submit_valid_d = 1'b0;
        prio_d         = 1'b0;
      end else begin
        push = req & ready;
        if (cand != 2'b00) begin
          pop[gnt_sel]   = 1'b1;
          submit_valid_d = 1'b1;
          submit_tag_d   = head[ENT_W-1:DATA_W];
          submit_val_d   = head[DATA_W-1:0];
          prio_d         = ~gnt_sel;
        end else begin
          submit_valid_d = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
          if (push[i]) begin
            mem_d[i][wptr_q[i]] = ent_in[i];
            wptr_d[i]           = wptr_q[i] + 1'b1;
          end
          if (pop[i]) rptr_d[i] = rptr_q[i] + 1'b1;
          cnt_d[i] = cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < 2; i++) begin
        for (int j = 0; j < FIFO_DEPTH; j++) mem_q[i][j] <= '0;
        rptr_q[i] <= '0;
        wptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      prio_q         <= 1'b0;
      submit_valid_q <= 1'b0;
      submit_tag_q   <= '0;
      submit_val_q   <= '0;
    end else begin
      mem_q          <= mem_d;
      rptr_q         <= rptr_d;
      wptr_q         <= wptr_d;
      cnt_q          <= cnt_d;
      prio_q         <= prio_d;
      submit_valid_q <= submit_valid_d;
      submit_tag_q   <= submit_tag_d;
      submit_val_q   <= submit_val_d;
    end
  end

  assign rs_ready     = ready[0];
  assign lsb_ready    = ready[1];
  assign submit_valid = submit_valid_q;
  assign submit_tag   = submit_tag_q;
  assign submit_val   = submit_val_q;
  assign busy         = cand[0] | cand[1] | submit_valid_q;

endmodule

// File: tb/tb_rob_submit_arbiter.sv
// Directed bench for rob_submit_arbiter: latency, round-robin order,
// backpressure, flush, pause and asynchronous reset.
module tb_rob_submit_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        predict_fail;
  logic        rs_valid;
  logic [3:0]  rs_tag;
  logic [31:0] rs_val;
  logic        rs_ready;
  logic        lsb_valid;
  logic [3:0]  lsb_tag;
  logic [31:0] lsb_val;
  logic        lsb_ready;
  logic [3:0]  submit_tag;
  logic [31:0] submit_val;
  logic        submit_valid;
  logic        busy;

  int tests = 0;
  int fails = 0;

  rob_submit_arbiter #(.TAG_W(4), .DATA_W(32), .FIFO_DEPTH(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .predict_fail(predict_fail),
    .rs_valid(rs_valid), .rs_tag(rs_tag), .rs_val(rs_val), .rs_ready(rs_ready),
    .lsb_valid(lsb_valid), .lsb_tag(lsb_tag), .lsb_val(lsb_val), .lsb_ready(lsb_ready),
    .submit_tag(submit_tag), .submit_val(submit_val), .submit_valid(submit_valid),
    .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk_sub(input string name, input logic v, input logic [3:0] t,
                         input logic [31:0] d);
    chk({name, ".valid"}, 64'(submit_valid), 64'(v));
    if (v) begin
      chk({name, ".tag"}, 64'(submit_tag), 64'(t));
      chk({name, ".val"}, 64'(submit_val), 64'(d));
    end
  endtask

  task automatic chk_rdy(input string name, input logic r, input logic l);
    chk({name, ".rs_ready"}, 64'(rs_ready), 64'(r));
    chk({name, ".lsb_ready"}, 64'(lsb_ready), 64'(l));
  endtask

  task automatic drv_rs(input logic v, input logic [3:0] t, input logic [31:0] d);
    rs_valid = v; rs_tag = t; rs_val = d;
  endtask

  task automatic drv_lsb(input logic v, input logic [3:0] t, input logic [31:0] d);
    lsb_valid = v; lsb_tag = t; lsb_val = d;
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; predict_fail = 1'b0;
    drv_rs(1'b0, 4'h0, 32'h0);
    drv_lsb(1'b0, 4'h0, 32'h0);
    #12;
    chk("reset.valid", 64'(submit_valid), 64'd0);
    chk("reset.tag", 64'(submit_tag), 64'd0);
    chk("reset.val", 64'(submit_val), 64'd0);
    chk("reset.busy", 64'(busy), 64'd0);
    chk_rdy("reset", 1'b1, 1'b1);
    rst_in = 1'b0;

    // single RS request
    drv_rs(1'b1, 4'd3, 32'h1234);
    tick();
    chk_sub("s1.e1", 1'b0, 4'd0, 32'd0);
    chk("s1.e1.busy", 64'(busy), 64'd1);
    drv_rs(1'b0, 4'd0, 32'd0);
    tick();
    chk_sub("s1.e2", 1'b1, 4'd3, 32'h1234);
    tick();
    chk_sub("s1.e3", 1'b0, 4'd0, 32'd0);
    chk("s1.e3.busy", 64'(busy), 64'd0);

    // flush to bring prio back to RS
    predict_fail = 1'b1;
    tick();
    predict_fail = 1'b0;
    chk_sub("pf0", 1'b0, 4'd0, 32'd0);

    // simultaneous RS and LSB
    drv_rs(1'b1, 4'd1, 32'hA);
    drv_lsb(1'b1, 4'd2, 32'hB);
    tick();
    chk_sub("s2.e1", 1'b0, 4'd0, 32'd0);
    drv_rs(1'b0, 4'd0, 32'd0);
    drv_lsb(1'b0, 4'd0, 32'd0);
    tick();
    chk_sub("s2.e2", 1'b1, 4'd1, 32'hA);
    tick();
    chk_sub("s2.e3", 1'b1, 4'd2, 32'hB);
    tick();
    chk_sub("s2.e4", 1'b0, 4'd0, 32'd0);
    chk("s2.e4.busy", 64'(busy), 64'd0);

    // RS back-to-back x3, prio is RS here
    drv_rs(1'b1, 4'd4, 32'h40);
    tick();
    chk_sub("s3.e1", 1'b0, 4'd0, 32'd0);
    chk_rdy("s3.e1", 1'b1, 1'b1);
    drv_rs(1'b1, 4'd5, 32'h50);
    tick();
    chk_sub("s3.e2", 1'b1, 4'd4, 32'h40);
    chk_rdy("s3.e2", 1'b1, 1'b1);
    drv_rs(1'b1, 4'd6, 32'h60);
    tick();
    chk_sub("s3.e3", 1'b1, 4'd5, 32'h50);
    chk_rdy("s3.e3", 1'b1, 1'b1);
    drv_rs(1'b0, 4'd0, 32'd0);
    tick();
    chk_sub("s3.e4", 1'b1, 4'd6, 32'h60);
    tick();
    chk_sub("s3.e5", 1'b0, 4'd0, 32'd0);
    chk("s3.e5.busy", 64'(busy), 64'd0);

    // both saturated, prio now LSB
    drv_rs(1'b1, 4'd8, 32'h100);
    drv_lsb(1'b1, 4'd12, 32'h200);
    tick();
    chk_sub("sat.e1", 1'b0, 4'd0, 32'd0);
    chk_rdy("sat.e1", 1'b1, 1'b1);
    drv_rs(1'b1, 4'd9, 32'h101);
    drv_lsb(1'b1, 4'd13, 32'h201);
    tick();
    chk_sub("sat.e2", 1'b1, 4'd12, 32'h200);
    chk_rdy("sat.e2", 1'b0, 1'b1);
    drv_rs(1'b1, 4'd10, 32'h102);
    drv_lsb(1'b1, 4'd14, 32'h202);
    tick();
    chk_sub("sat.e3", 1'b1, 4'd8, 32'h100);
    chk_rdy("sat.e3", 1'b1, 1'b0);
    drv_lsb(1'b1, 4'd15, 32'h203);
    tick();
    chk_sub("sat.e4", 1'b1, 4'd13, 32'h201);
    chk_rdy("sat.e4", 1'b0, 1'b1);
    drv_rs(1'b1, 4'd11, 32'h103);
    tick();
    chk_sub("sat.e5", 1'b1, 4'd9, 32'h101);
    chk_rdy("sat.e5", 1'b1, 1'b0);

    // flush with requests presented in the same cycle
    drv_lsb(1'b1, 4'd0, 32'h204);
    predict_fail = 1'b1;
    tick();
    chk("fl.e1.valid", 64'(submit_valid), 64'd0);
    chk("fl.e1.tag_hold", 64'(submit_tag), 64'd9);
    chk("fl.e1.val_hold", 64'(submit_val), 64'h101);
    chk("fl.e1.busy", 64'(busy), 64'd0);
    chk_rdy("fl.e1", 1'b1, 1'b1);
    predict_fail = 1'b0;
    drv_rs(1'b0, 4'd0, 32'd0);
    drv_lsb(1'b0, 4'd0, 32'd0);
    tick();
    chk("fl.e2.valid", 64'(submit_valid), 64'd0);
    chk("fl.e2.busy", 64'(busy), 64'd0);
    tick();
    chk("fl.e3.valid", 64'(submit_valid), 64'd0);

    // pause with entries buffered, prio reset to RS by flush
    drv_rs(1'b1, 4'd1, 32'h301);
    drv_lsb(1'b1, 4'd2, 32'h302);
    tick();
    chk_sub("pa.e1", 1'b0, 4'd0, 32'd0);
    drv_rs(1'b1, 4'd3, 32'h303);
    drv_lsb(1'b1, 4'd4, 32'h304);
    tick();
    chk_sub("pa.e2", 1'b1, 4'd1, 32'h301);
    chk_rdy("pa.e2", 1'b1, 1'b0);
    rdy_in = 1'b0;
    drv_rs(1'b1, 4'd5, 32'h305);
    drv_lsb(1'b0, 4'd0, 32'd0);
    tick();
    chk_sub("pa.h1", 1'b1, 4'd1, 32'h301);
    chk_rdy("pa.h1", 1'b1, 1'b0);
    predict_fail = 1'b1;
    tick();
    chk_sub("pa.h2", 1'b1, 4'd1, 32'h301);
    chk("pa.h2.busy", 64'(busy), 64'd1);
    predict_fail = 1'b0;
    tick();
    chk_sub("pa.h3", 1'b1, 4'd1, 32'h301);
    chk_rdy("pa.h3", 1'b1, 1'b0);
    rdy_in = 1'b1;
    drv_rs(1'b0, 4'd0, 32'd0);
    tick();
    chk_sub("pa.r1", 1'b1, 4'd2, 32'h302);
    tick();
    chk_sub("pa.r2", 1'b1, 4'd3, 32'h303);
    tick();
    chk_sub("pa.r3", 1'b1, 4'd4, 32'h304);
    tick();
    chk_sub("pa.r4", 1'b0, 4'd0, 32'd0);
    chk("pa.r4.busy", 64'(busy), 64'd0);

    // asynchronous reset between edges
    drv_rs(1'b1, 4'd7, 32'h77);
    drv_lsb(1'b1, 4'd8, 32'h88);
    tick();
    chk_sub("ar.e1", 1'b0, 4'd0, 32'd0);
    drv_rs(1'b0, 4'd0, 32'd0);
    drv_lsb(1'b0, 4'd0, 32'd0);
    tick();
    chk_sub("ar.e2", 1'b1, 4'd7, 32'h77);
    #2 rst_in = 1'b1;
    #1;
    chk("ar.valid", 64'(submit_valid), 64'd0);
    chk("ar.tag", 64'(submit_tag), 64'd0);
    chk("ar.val", 64'(submit_val), 64'd0);
    chk("ar.busy", 64'(busy), 64'd0);
    chk_rdy("ar", 1'b1, 1'b1);
    #1 rst_in = 1'b0;
    drv_rs(1'b1, 4'd3, 32'h1234);
    tick();
    chk_sub("ar.s1.e1", 1'b0, 4'd0, 32'd0);
    chk("ar.s1.e1.busy", 64'(busy), 64'd1);
    drv_rs(1'b0, 4'd0, 32'd0);
    tick();
    chk_sub("ar.s1.e2", 1'b1, 4'd3, 32'h1234);
    tick();
    chk_sub("ar.s1.e3", 1'b0, 4'd0, 32'd0);
    chk("ar.s1.e3.busy", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
